// File: rtl/axi_4_pkg.sv
// Shared types for the AXI4 responder-side handshake controller.
// Imported by the slave controller top.
package axi_4_pkg;

  typedef enum logic [2:0] {
    SLAVE_IDLE = 3'd0,
    RD_FETCH   = 3'd1,
    RD_BEAT    = 3'd2,
    WR_ACCEPT  = 3'd3,
    WR_RESP    = 3'd4
  } axi_4_slave_states_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_4_slave_controller.sv
// AXI4 slave handshake controller: paces read beats against a fixed
// memory latency and accepts write bursts, emitting datapath strobes.
module axi_4_slave_controller
  import axi_4_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_arvalid,
  input  logic [LEN_W-1:0] m_arlen,
  input  logic             m_rready,
  input  logic             m_awvalid,
  input  logic [LEN_W-1:0] m_awlen,
  input  logic             m_wvalid,
  input  logic             m_wlast,
  input  logic             m_bready,
  output logic             s_arready,
  output logic             s_rvalid,
  output logic             s_rlast,
  output logic [1:0]       s_rresp,
  output logic             s_awready,
  output logic             s_wready,
  output logic             s_bvalid,
  output logic [1:0]       s_bresp,
  output logic             ar_capture,
  output logic             aw_capture,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic             addr_incr
);

  localparam int LAT_W =
    (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD =
    LAT_W'(READ_LATENCY - 1);

  axi_4_slave_states_e state_q, state_d;
  logic [LEN_W-1:0] beats_left_q, beats_left_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             aw_done_q, aw_done_d;
  logic [LEN_W-1:0] wlen_q, wlen_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;

  logic             idle_aw;
  logic             wr_phase;
  logic             w_fire;
  logic [LEN_W-1:0] cur_wcnt;
  logic [LEN_W-1:0] cur_wlen;
  logic             w_in_range;
  logic             w_overrun;
  logic             r_fire;
  logic             r_last;

  // An AW accepted in idle uses the incoming length and a zero count
  // so a W beat in the same cycle is handled like any WR_ACCEPT beat.
  assign idle_aw    = (state_q == SLAVE_IDLE) && m_awvalid && !m_arvalid;
  assign wr_phase   = idle_aw || ((state_q == WR_ACCEPT) && aw_done_q);
  assign w_fire     = wr_phase && m_wvalid;
  assign cur_wcnt   = idle_aw ? '0 : wcnt_q;
  assign cur_wlen   = idle_aw ? m_awlen : wlen_q;
  assign w_in_range = cur_wcnt <= cur_wlen;
  assign w_overrun  = w_fire && !m_wlast && (cur_wcnt >= cur_wlen);
  assign r_fire     = (state_q == RD_BEAT) && m_rready;
  assign r_last     = (beats_left_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SLAVE_IDLE;
      beats_left_q <= '0;
      lat_cnt_q    <= '0;
      aw_done_q    <= 1'b0;
      wlen_q       <= '0;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      lat_cnt_q    <= lat_cnt_d;
      aw_done_q    <= aw_done_d;
      wlen_q       <= wlen_d;
      wcnt_q       <= wcnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    lat_cnt_d    = lat_cnt_q;
    aw_done_d    = aw_done_q;
    wlen_d       = wlen_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    unique case (state_q)
      SLAVE_IDLE: begin
        if (m_arvalid) begin
          beats_left_d = m_arlen;
          lat_cnt_d    = LAT_RELOAD;
          state_d      = RD_FETCH;
        end else if (m_awvalid) begin
          aw_done_d = 1'b1;
          wlen_d    = m_awlen;
          wcnt_d    = '0;
          state_d   = WR_ACCEPT;
        end
      end
      RD_FETCH: begin
        if (lat_cnt_q == '0) begin
          state_d = RD_BEAT;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RD_BEAT: begin
        if (r_fire) begin
          if (r_last) begin
            state_d = SLAVE_IDLE;
          end else begin
            beats_left_d = beats_left_q - 1'b1;
            lat_cnt_d    = LAT_RELOAD;
            state_d      = RD_FETCH;
          end
        end
      end
      WR_ACCEPT: begin
      end
      WR_RESP: begin
        if (m_bready) begin
          aw_done_d = 1'b0;
          err_d     = 1'b0;
          wcnt_d    = '0;
          wlen_d    = '0;
          state_d   = SLAVE_IDLE;
        end
      end
      default: state_d = SLAVE_IDLE;
    endcase
    if (w_fire) begin
      wcnt_d = (&cur_wcnt) ? cur_wcnt : cur_wcnt + 1'b1;
      if (w_overrun) err_d = 1'b1;
      if (m_wlast) begin
        // Sticky err keeps a saturated overrun from looking clean.
        err_d   = err_q | (cur_wcnt != cur_wlen);
        state_d = WR_RESP;
      end
    end
  end

  always_comb begin
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rresp    = RESP_OKAY;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bresp    = RESP_OKAY;
    ar_capture = 1'b0;
    aw_capture = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    addr_incr  = 1'b0;
    unique case (state_q)
      SLAVE_IDLE: begin
        s_arready = 1'b1;
        s_awready = !m_arvalid;
        if (m_arvalid) begin
          ar_capture = 1'b1;
          mem_rd_en  = 1'b1;
        end else if (m_awvalid) begin
          aw_capture = 1'b1;
        end
      end
      RD_BEAT: begin
        s_rvalid = 1'b1;
        s_rlast  = r_last;
        if (r_fire && !r_last) begin
          addr_incr = 1'b1;
          mem_rd_en = 1'b1;
        end
      end
      WR_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: begin
      end
    endcase
    s_wready = wr_phase;
    if (w_fire) begin
      mem_wr_en = w_in_range;
      addr_incr = !m_wlast;
    end
    if (!reset) begin
      s_arready  = 1'b0;
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      s_bresp    = RESP_OKAY;
      s_bvalid   = 1'b0;
      ar_capture = 1'b0;
      aw_capture = 1'b0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      addr_incr  = 1'b0;
      s_rvalid   = 1'b0;
      s_rlast    = 1'b0;
    end
  end

endmodule

// File: doc/axi_4_slave_controller.md
Name: axi_4_slave_controller

Overview:
Memory-side AXI4 handshake controller; the responder counterpart to the VLSU master controller. It accepts read and write address/data handshakes from the master and paces read beats against a fixed memory latency. It generates valid/ready/last/response signals plus datapath strobes that tell the memory datapath to latch addresses, read, write and advance the beat address. It carries no data or address buses itself.

Parameters:
READ_LATENCY, 2, cycles from mem_rd_en to read data available (must be >=1)
LEN_W, 8, width of AXI burst length fields

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
m_arvalid  in  1  read address valid
m_arlen  in  LEN_W  read burst length minus 1
m_rready  in  1  master accepts read beat
m_awvalid  in  1  write address valid
m_awlen  in  LEN_W  write burst length minus 1
m_wvalid  in  1  write data valid
m_wlast  in  1  final write beat
m_bready  in  1  master accepts write response
s_arready  out  1  read address accepted
s_rvalid  out  1  read beat valid
s_rlast  out  1  final read beat
s_rresp  out  2  read response (always OKAY 2'b00)
s_awready  out  1  write address accepted
s_wready  out  1  write beat accepted
s_bvalid  out  1  write response valid
s_bresp  out  2  OKAY 2'b00 or SLVERR 2'b10
ar_capture  out  1  pulse: datapath latches read address
aw_capture  out  1  pulse: datapath latches write address
mem_rd_en  out  1  pulse: memory starts beat fetch
mem_wr_en  out  1  pulse: memory writes current beat
addr_incr  out  1  pulse: datapath advances beat address

Behaviour:
- Outputs are combinational from state, flags and inputs. On reset all outputs are 0, state is SLAVE_IDLE, and counters and flags are cleared. Reset asserted mid-burst aborts the burst immediately with no response.
- States: SLAVE_IDLE, RD_FETCH, RD_BEAT, WR_ACCEPT, WR_RESP.
- SLAVE_IDLE:
  - s_arready=1.
  - s_awready=!m_arvalid.
  - Read has priority when both valids are high.
  - m_arvalid: ar_capture=1, mem_rd_en=1, beats_left<=m_arlen, lat_cnt<=READ_LATENCY-1, go to RD_FETCH.
  - Else m_awvalid: aw_capture=1, aw_done<=1, wlen<=m_awlen, wcnt<=0, go to WR_ACCEPT. A W beat presented in the same cycle is accepted (s_wready=1) and handled as in WR_ACCEPT.
- RD_FETCH: lat_cnt decrements each cycle; at 0 go to RD_BEAT. READ_LATENCY=1 spends exactly 1 cycle here.
- RD_BEAT:
  - s_rvalid=1; s_rlast=(beats_left==0).
  - Hold while m_rready=0; all outputs stay stable.
  - On handshake with s_rlast: go to SLAVE_IDLE.
  - On handshake without s_rlast: addr_incr=1, mem_rd_en=1, beats_left--, lat_cnt reload, go to RD_FETCH.
- Read beat throughput: 1 beat per READ_LATENCY+1 cycles with m_rready held high.
- WR_ACCEPT:
  - s_awready=0; s_wready=1.
  - Each m_wvalid&&s_wready: mem_wr_en=1, addr_incr=1 (unless m_wlast), wcnt++.
  - On beat with m_wlast: err<=(wcnt!=wlen), go to WR_RESP.
  - Overrun, i.e. wcnt==wlen without m_wlast: beats are still accepted but not written (mem_wr_en=0), err<=1.
  - wcnt saturates at all-ones.
- WR_RESP:
  - s_bvalid=1; s_bresp = err ? 2'b10 : 2'b00.
  - Hold until m_bready, then clear flags and go to SLAVE_IDLE. Earliest new request accepted the next cycle.
- W data never precedes AW: s_wready=0 in SLAVE_IDLE unless m_awvalid&&!m_arvalid in that cycle.
- Length-0 bursts are 1 beat: s_rlast is high on the first read beat, and m_wlast on the first write beat gives OKAY.

Decomposition:
- axi_4_pkg: add axi_4_slave_states_e, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- No sub-module; the latency/beat counters are in-line.

Test Plan:
- Read, arlen=3, READ_LATENCY=2, m_rready=1 -> 4 s_rvalid beats 3 cycles apart; s_rlast on the 4th only; 4 mem_rd_en pulses; 3 addr_incr pulses; back to idle.
- Read, arlen=0, m_rready held low 5 cycles -> s_rvalid+s_rlast held stable 5 cycles; completes on the cycle m_rready rises.
- Write, awlen=2, AW and W together, 3 beats with wlast on the 3rd -> 3 mem_wr_en pulses; s_bvalid with s_bresp=00 until m_bready.
- Write, awlen=3, wlast on beat 2 -> s_bresp=10.
- Write, awlen=0, 3 beats with wlast on the 3rd -> only 1 mem_wr_en; s_bresp=10.
- m_arvalid and m_awvalid together in idle -> read served first (s_awready=0); write accepted after s_rlast.
- Reset pulsed mid read burst -> all outputs 0 next cycle; a new read then completes normally.
